alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised successor of the combinational ALU: registered W-bit ALU with start/busy/done handshake.
//   Keeps the single-cycle logic/arith/shift/clip ops and adds variable shifts, iterative signed/unsigned
//   multiply and divide with HI/LO results, and an error flag. Sits in EX stage; control stalls on busy.
// PARAMETERS
//   W        32    datapath width (>=8, even)
//   SHW      5     shift-amount width, clog2(W)
//   CLIP_LO  0     signed lower clamp for CLIP op
//   CLIP_HI  255   signed upper clamp for CLIP op
// PORTS
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      launch op; sampled only when busy=0
//   ctrl   in   6      opcode (below)
//   a      in   W      operand s / dividend / multiplicand
//   b      in   W      operand t / divisor / multiplier
//   shamt  in   SHW    shift amount for variable shifts
//   r      out  W      result / LO (product low, quotient)
//   r2     out  W      HI (product high, remainder); 0 for single-cycle ops
//   z      out  1      r==0
//   busy   out  1      multi-cycle op in progress
//   done   out  1      one-cycle pulse: r/r2/z/err valid
//   err    out  1      signed ADD/SUB overflow, divide-by-zero, illegal opcode
// BEHAVIOUR
//   Opcodes: 00 AND,01 OR,02 ADD(ovf),03 ADDU,04 XOR,05 NOR,06 SUB(ovf),07 SLT,08 SLTU,09 LUI (b<<W/2),
//     0A SLLV,0B SRLV,0C SRAV (b by shamt),13 MULU,14 MUL,15 DIVU,16 DIV,30 CLIP; others illegal.
//   Reset: r=0,r2=0,z=1,busy=0,done=0,err=0, FSM->IDLE, counter=0. rst mid-op aborts, no done pulse.
//   FSM IDLE->(start & multi-cycle op) RUN->FIN->IDLE; IDLE->(start & single-cycle/illegal) IDLE.
//   Single-cycle: start sampled at edge k -> r,r2,z,err,done updated at edge k+1; done high one cycle.
//   Multi-cycle: operands latched at edge k, busy=1 from k; RUN W iterations (1 bit/cycle);
//     FIN applies sign fix-up; done=1, busy=0 after edge k+W+1. r/r2 unchanged until done.
//   start while busy=1 ignored; start coinciding with done edge accepted only once busy=0 is visible.
//   MUL/MULU: 2W-bit product {r2,r}; MUL uses magnitudes, negates if signs differ; no err.
//   DIV/DIVU: restoring division. DIV truncates toward zero; remainder takes dividend sign.
//     b==0: r=all ones, r2=a, err=1, still W+1 latency. DIV of -2^(W-1) by -1: r=-2^(W-1), r2=0, err=1.
//   ADD/SUB err on signed overflow; result still wraps. ADDU/SLTU never err.
//   CLIP: signed a clamped to [CLIP_LO,CLIP_HI]. Illegal: r=0,r2=0,z=1,err=1, single-cycle.
//   Outputs hold between ops; done and err are updated only with each completed op.
// CONFIGURATION
//   ALU_SEQ_DIV_EN defined: DIV/DIVU implemented as above.
//   Not defined: divider logic absent; 15/16 treated as illegal (single-cycle, err=1, r=r2=0).
// TESTING (W=32 unless stated)
//   ADD a=7,b=-3, start edge k -> r=4,z=0,err=0,done only in cycle k+1; ADD 0x7FFFFFFF+1 -> r=0x80000000,err=1
//   MULU a=0xFFFFFFFF,b=2 -> r=0xFFFFFFFE,r2=1, busy 33 cycles, done at k+33; MUL -3*5 -> r=0xFFFFFFF1,r2=all ones
//   DIV -7/2 -> r=0xFFFFFFFD,r2=0xFFFFFFFF; DIVU 5/0 -> r=0xFFFFFFFF,r2=5,err=1; without macro DIV -> err=1 at k+1
//   MUL started, rst at k+10 -> busy=0,r=0,z=1,no done pulse; new ADD at k+11 completes at k+12
//   CLIP a=300 -> 255; a=-4 -> 0; SRAV b=0x80000000,shamt=4 -> 0xF8000000
//   start pulsed with ANDs every cycle during MULU busy -> ignored, single done, r/r2 = product

Source files
------------

// File: rtl/alu_seq.sv
// Registered W-bit ALU with start/busy/done handshake and bit-serial multiply/divide (HI/LO results).
// Define ALU_SEQ_DIV_EN to build the divider; without it DIVU/DIV decode as illegal opcodes.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete on the following edge
// RUN   | one multiply/divide bit per cycle while cnt_q counts down to zero
// FIN   | sign fix-up, results written, done pulsed, back to IDLE

module alu_seq #(
    parameter int W       = 32,
    parameter int SHW     = 5,
    parameter int CLIP_LO = 0,
    parameter int CLIP_HI = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [5:0]     ctrl,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [SHW-1:0] shamt,
    output logic [W-1:0]   r,
    output logic [W-1:0]   r2,
    output logic           z,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h01;
    localparam logic [5:0] OP_ADD  = 6'h02;
    localparam logic [5:0] OP_ADDU = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_NOR  = 6'h05;
    localparam logic [5:0] OP_SUB  = 6'h06;
    localparam logic [5:0] OP_SLT  = 6'h07;
    localparam logic [5:0] OP_SLTU = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h09;
    localparam logic [5:0] OP_SLLV = 6'h0A;
    localparam logic [5:0] OP_SRLV = 6'h0B;
    localparam logic [5:0] OP_SRAV = 6'h0C;
    localparam logic [5:0] OP_MULU = 6'h13;
    localparam logic [5:0] OP_MUL  = 6'h14;
    localparam logic [5:0] OP_DIVU = 6'h15;
    localparam logic [5:0] OP_DIV  = 6'h16;
    localparam logic [5:0] OP_CLIP = 6'h30;

    localparam logic signed [W-1:0] CLIP_LO_W = W'(CLIP_LO);
    localparam logic signed [W-1:0] CLIP_HI_W = W'(CLIP_HI);
    localparam logic [SHW-1:0]      CNT_LOAD  = SHW'(W - 1);
    localparam logic [W-1:0]        INT_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [5:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [SHW-1:0] shamt_q;
    logic           sc_pend;
    logic [W-1:0]   hi_q, lo_q, mcand_q;
    logic [SHW-1:0] cnt_q;

    logic           accept, is_multi, start_div, start_signed;
    logic [W-1:0]   a_mag, b_mag;
    logic           op_div, op_signed;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi, mul_lo, div_hi, div_lo;
    logic [W-1:0]   add_s, sub_s, sc_r;
    logic           sc_err;
    logic [2*W-1:0] prod, prod_f;
    logic [W-1:0]   quo_f, rem_f, fin_r, fin_r2;
    logic           fin_err;

    // Restoring divider step: remainder in hi_q, dividend shifts out of lo_q as quotient shifts in.
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;

    logic [W:0] rem_sh;
    logic       q_bit;

    always_comb begin
        rem_sh = {hi_q, lo_q[W-1]};
        q_bit  = (rem_sh >= {1'b0, mcand_q});
        div_hi = q_bit ? W'(rem_sh - {1'b0, mcand_q}) : rem_sh[W-1:0];
        div_lo = {lo_q[W-2:0], q_bit};
    end
`else
    localparam bit DIV_EN = 1'b0;

    assign div_hi = '0;
    assign div_lo = '0;
`endif

    always_comb begin
        start_div    = DIV_EN && ((ctrl == OP_DIVU) || (ctrl == OP_DIV));
        is_multi     = (ctrl == OP_MULU) || (ctrl == OP_MUL) || start_div;
        start_signed = (ctrl == OP_MUL) || (ctrl == OP_DIV);
        a_mag        = (start_signed && a[W-1]) ? -a : a;
        b_mag        = (start_signed && b[W-1]) ? -b : b;
    end

    assign accept = start && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (accept && is_multi) state_nxt = RUN;
            RUN:     if (cnt_q == '0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_div    = DIV_EN && ((op_q == OP_DIVU) || (op_q == OP_DIV));
        op_signed = (op_q == OP_MUL) || (op_q == OP_DIV);
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi    = mul_sum[W:1];
        mul_lo    = {mul_sum[0], lo_q[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shamt_q <= '0;
            sc_pend <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            sc_pend <= accept && !is_multi;
            if (accept) begin
                op_q    <= ctrl;
                a_q     <= a;
                b_q     <= b;
                shamt_q <= shamt;
            end
            if (accept && is_multi) begin
                hi_q    <= '0;
                lo_q    <= start_div ? a_mag : b_mag;
                mcand_q <= start_div ? b_mag : a_mag;
                cnt_q   <= CNT_LOAD;
            end else if (state == RUN) begin
                hi_q <= op_div ? div_hi : mul_hi;
                lo_q <= op_div ? div_lo : mul_lo;
                if (cnt_q != '0) cnt_q <= cnt_q - SHW'(1);
            end
        end
    end

    always_comb begin
        add_s  = a_q + b_q;
        sub_s  = a_q - b_q;
        sc_r   = '0;
        sc_err = 1'b0;
        case (op_q)
            OP_AND:  sc_r = a_q & b_q;
            OP_OR:   sc_r = a_q | b_q;
            OP_ADD: begin
                sc_r   = add_s;
                sc_err = (a_q[W-1] == b_q[W-1]) && (add_s[W-1] != a_q[W-1]);
            end
            OP_ADDU: sc_r = add_s;
            OP_XOR:  sc_r = a_q ^ b_q;
            OP_NOR:  sc_r = ~(a_q | b_q);
            OP_SUB: begin
                sc_r   = sub_s;
                sc_err = (a_q[W-1] != b_q[W-1]) && (sub_s[W-1] != a_q[W-1]);
            end
            OP_SLT:  sc_r = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: sc_r = {{(W-1){1'b0}}, (a_q < b_q)};
            OP_LUI:  sc_r = b_q << (W / 2);
            OP_SLLV: sc_r = b_q << shamt_q;
            OP_SRLV: sc_r = b_q >> shamt_q;
            OP_SRAV: sc_r = $unsigned($signed(b_q) >>> shamt_q);
            OP_CLIP: begin
                if ($signed(a_q) < CLIP_LO_W) begin
                    sc_r = CLIP_LO_W;
                end else if ($signed(a_q) > CLIP_HI_W) begin
                    sc_r = CLIP_HI_W;
                end else begin
                    sc_r = a_q;
                end
            end
            default: sc_err = 1'b1;
        endcase
    end

    // Iteration ran on magnitudes; restore signs here. Remainder follows the dividend's sign.
    always_comb begin
        prod    = {hi_q, lo_q};
        prod_f  = (op_signed && (a_q[W-1] ^ b_q[W-1])) ? -prod : prod;
        quo_f   = (op_signed && (a_q[W-1] ^ b_q[W-1])) ? -lo_q : lo_q;
        rem_f   = (op_signed && a_q[W-1]) ? -hi_q : hi_q;
        fin_r   = prod_f[W-1:0];
        fin_r2  = prod_f[2*W-1:W];
        fin_err = 1'b0;
        if (op_div) begin
            fin_r  = quo_f;
            fin_r2 = rem_f;
            if (b_q == '0) begin
                fin_r   = '1;
                fin_r2  = a_q;
                fin_err = 1'b1;
            end else if (op_signed && (a_q == INT_MIN) && (b_q == '1)) begin
                fin_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r    <= '0;
            r2   <= '0;
            z    <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIN) begin
                r    <= fin_r;
                r2   <= fin_r2;
                z    <= (fin_r == '0);
                err  <= fin_err;
                done <= 1'b1;
            end else if (sc_pend) begin
                r    <= sc_r;
                r2   <= '0;
                z    <= (sc_r == '0);
                err  <= sc_err;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results queued at launch, popped and checked at done.
// Division cases follow the ALU_SEQ_DIV_EN build option.

module tb_alu_seq;

    localparam int W = 32;

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h01;
    localparam logic [5:0] OP_ADD  = 6'h02;
    localparam logic [5:0] OP_ADDU = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_NOR  = 6'h05;
    localparam logic [5:0] OP_SUB  = 6'h06;
    localparam logic [5:0] OP_SLT  = 6'h07;
    localparam logic [5:0] OP_SLTU = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h09;
    localparam logic [5:0] OP_SLLV = 6'h0A;
    localparam logic [5:0] OP_SRLV = 6'h0B;
    localparam logic [5:0] OP_SRAV = 6'h0C;
    localparam logic [5:0] OP_MULU = 6'h13;
    localparam logic [5:0] OP_MUL  = 6'h14;
    localparam logic [5:0] OP_DIVU = 6'h15;
    localparam logic [5:0] OP_DIV  = 6'h16;
    localparam logic [5:0] OP_CLIP = 6'h30;

    logic         clk, rst, start;
    logic [5:0]   ctrl;
    logic [W-1:0] a, b;
    logic [4:0]   shamt;
    logic [W-1:0] r, r2;
    logic         z, busy, done, err;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] r2;
        logic         err;
        int           lat;
        int           busy_cyc;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.W(W), .SHW(5), .CLIP_LO(0), .CLIP_HI(255)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b), .shamt(shamt),
        .r(r), .r2(r2), .z(z), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: end of test not reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that sampled start.
    task automatic launch(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [4:0] sh, input logic [W-1:0] er, input logic [W-1:0] er2,
                          input logic eerr, input bit multi);
        exp_t e;
        ctrl  = op;
        a     = av;
        b     = bv;
        shamt = sh;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        e.r        = er;
        e.r2       = er2;
        e.err      = eerr;
        e.lat      = multi ? W + 1 : 1;
        e.busy_cyc = multi ? W + 1 : 0;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input bit spam);
        exp_t e;
        int   cyc;
        int   bcyc;
        cyc  = 0;
        bcyc = (busy === 1'b1) ? 1 : 0;
        while (cyc < 100) begin
            if (spam) begin
                ctrl  = OP_AND;
                a     = '1;
                b     = '1;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
            if (busy === 1'b1) bcyc++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, ".lat"},  64'(cyc),  64'(e.lat));
        chk({tag, ".busy"}, 64'(bcyc), 64'(e.busy_cyc));
        chk({tag, ".r"},    64'(r),    64'(e.r));
        chk({tag, ".r2"},   64'(r2),   64'(e.r2));
        chk({tag, ".z"},    64'(z),    64'(e.r == '0));
        chk({tag, ".err"},  64'(err),  64'(e.err));
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 64'(done), 64'd0);
        chk({tag, ".hold"},  64'(r),    64'(e.r));
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [4:0] sh, input logic [W-1:0] er,
                       input logic [W-1:0] er2, input logic eerr, input bit multi);
        launch(op, av, bv, sh, er, er2, eerr, multi);
        collect(tag, 1'b0);
    endtask

    initial begin
        logic [W-1:0]       av, bv;
        logic [63:0]        p;
        logic signed [63:0] sp;
        int                 base;

        rst   = 1'b1;
        start = 1'b0;
        ctrl  = '0;
        a     = '0;
        b     = '0;
        shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.r",    64'(r),    64'd0);
        chk("rst.r2",   64'(r2),   64'd0);
        chk("rst.z",    64'(z),    64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.err",  64'(err),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("add",       OP_ADD,  32'd7,        32'hFFFFFFFD, 5'd0,  32'd4,        '0, 1'b0, 1'b0);
        run("add_ovf",   OP_ADD,  32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, '0, 1'b1, 1'b0);
        run("sub_ovf",   OP_SUB,  32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, '0, 1'b1, 1'b0);
        run("sub",       OP_SUB,  32'd5,        32'd9,        5'd0,  32'hFFFFFFFC, '0, 1'b0, 1'b0);
        run("addu_wrap", OP_ADDU, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        '0, 1'b0, 1'b0);
        run("and",       OP_AND,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, '0, 1'b0, 1'b0);
        run("or",        OP_OR,   32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, '0, 1'b0, 1'b0);
        run("xor",       OP_XOR,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h00000FF0, '0, 1'b0, 1'b0);
        run("nor",       OP_NOR,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'hFFFF000F, '0, 1'b0, 1'b0);
        run("slt",       OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        '0, 1'b0, 1'b0);
        run("sltu",      OP_SLTU, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        '0, 1'b0, 1'b0);
        run("lui",       OP_LUI,  32'd0,        32'h00001234, 5'd0,  32'h12340000, '0, 1'b0, 1'b0);
        run("sllv",      OP_SLLV, 32'd0,        32'd1,        5'd31, 32'h80000000, '0, 1'b0, 1'b0);
        run("srlv",      OP_SRLV, 32'd0,        32'h80000000, 5'd31, 32'd1,        '0, 1'b0, 1'b0);
        run("srav",      OP_SRAV, 32'd0,        32'h80000000, 5'd4,  32'hF8000000, '0, 1'b0, 1'b0);
        run("clip_hi",   OP_CLIP, 32'd300,      32'd0,        5'd0,  32'd255,      '0, 1'b0, 1'b0);
        run("clip_lo",   OP_CLIP, 32'hFFFFFFFC, 32'd0,        5'd0,  32'd0,        '0, 1'b0, 1'b0);
        run("clip_mid",  OP_CLIP, 32'd100,      32'd0,        5'd0,  32'd100,      '0, 1'b0, 1'b0);
        run("illegal",   6'h3F,   32'd9,        32'd9,        5'd0,  32'd0,        '0, 1'b1, 1'b0);

`ifdef ALU_SEQ_DIV_EN
        run("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1);
        run("div_negb",  OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd0, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b1);
        run("divu",      OP_DIVU, 32'd100,      32'd7,        5'd0, 32'd14,       32'd2,        1'b0, 1'b1);
        run("divu_zero", OP_DIVU, 32'd5,        32'd0,        5'd0, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b1);
        run("div_zero",  OP_DIV,  32'hFFFFFFFA, 32'd0,        5'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b1);
        run("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'd0,        1'b1, 1'b1);
`else
        run("div_off",   OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        run("divu_off",  OP_DIVU, 32'd5,        32'd0,        5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
`endif

        run("mulu_max",  OP_MULU, 32'hFFFFFFFF, 32'd2,        5'd0, 32'hFFFFFFFE, 32'd1,        1'b0, 1'b1);
        run("mul_neg",   OP_MUL,  32'hFFFFFFFD, 32'd5,        5'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b1);
        run("mul_min2",  OP_MUL,  32'h80000000, 32'h80000000, 5'd0, 32'd0,        32'h40000000, 1'b0, 1'b1);
        run("mul_minm1", OP_MUL,  32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'd0,        1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            av = $urandom();
            bv = $urandom();
            p  = {32'd0, av} * {32'd0, bv};
            run($sformatf("mulu_rnd%0d", i), OP_MULU, av, bv, 5'd0, p[31:0], p[63:32], 1'b0, 1'b1);
            sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
            run($sformatf("mul_rnd%0d", i), OP_MUL, av, bv, 5'd0, sp[31:0], sp[63:32], 1'b0, 1'b1);
        end

        // Reset ten edges into a MUL: no result, no done, then an ADD goes straight through.
        run("pre_abort", OP_CLIP, 32'd100, 32'd0, 5'd0, 32'd100, '0, 1'b0, 1'b0);
        base  = done_cnt;
        ctrl  = OP_MUL;
        a     = 32'd5;
        b     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.r",    64'(r),    64'd0);
        chk("abort.r2",   64'(r2),   64'd0);
        chk("abort.z",    64'(z),    64'd1);
        chk("abort.done", 64'(done_cnt - base), 64'd0);
        run("post_abort", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, '0, 1'b0, 1'b0);

        // AND starts held high through a MULU, including on its done edge.
        base = done_cnt;
        launch(OP_MULU, 32'hFFFFFFFF, 32'd2, 5'd0, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b1);
        collect("spam", 1'b1);
        @(posedge clk);
        #1;
        chk("spam.dones", 64'(done_cnt - base), 64'd1);
        chk("spam.r2",    64'(r2), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
